wb_mem_arbiter: RTL

Three-master Wishbone B3 arbiter that shares the single main-RAM slave port (`wb_ram`) between the debug master (`adbg_top`), the CPU data bus and the CPU instruction bus. It sits between the masters' `wb_m2s_*`/`wb_s2m_*` nets and the memory slave. Each grant is held for a whole Wishbone cycle, including registered-feedback bursts. A per-transfer watchdog answers a stuck slave with an error.

---
 rtl/wb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_mem_arbiter.sv
// Three-master Wishbone B3 arbiter for the shared main-RAM port, with a per-transfer watchdog.
// Define WB_MEM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration (fixed m0 > m1 > m2 otherwise).
module wb_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,

    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,

    input  logic [AW-1:0]   m2_adr_i,
    input  logic [DW-1:0]   m2_dat_i,
    input  logic [DW/8-1:0] m2_sel_i,
    input  logic            m2_we_i,
    input  logic            m2_cyc_i,
    input  logic            m2_stb_i,
    input  logic [2:0]      m2_cti_i,
    input  logic [1:0]      m2_bte_i,
    output logic [DW-1:0]   m2_dat_o,
    output logic            m2_ack_o,
    output logic            m2_err_o,
    output logic            m2_rty_o,

    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i
);

    localparam int SW = DW / 8;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_q;
    logic [1:0]      own_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    logic [1:0]      grant_s;
    logic            any_cyc_s;
    logic            busy_s;
    logic            resp_s;
    logic            timeout_s;

    logic [AW-1:0]   o_adr_s;
    logic [DW-1:0]   o_dat_s;
    logic [SW-1:0]   o_sel_s;
    logic            o_we_s;
    logic            o_cyc_s;
    logic            o_stb_s;
    logic [2:0]      o_cti_s;
    logic [1:0]      o_bte_s;

    assign any_cyc_s = m0_cyc_i | m1_cyc_i | m2_cyc_i;

`ifdef WB_MEM_ARBITER_ROUND_ROBIN_EN
    logic [1:0] last_q;

    // Round-robin: search starts at the master after the previous owner.
    always_comb begin
        grant_s = 2'd0;
        case (last_q)
            2'd0:    grant_s = m1_cyc_i ? 2'd1 : (m2_cyc_i ? 2'd2 : 2'd0);
            2'd1:    grant_s = m2_cyc_i ? 2'd2 : (m0_cyc_i ? 2'd0 : 2'd1);
            default: grant_s = m0_cyc_i ? 2'd0 : (m1_cyc_i ? 2'd1 : 2'd2);
        endcase
    end

    // Remember the most recent winner to rotate priority.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            last_q <= 2'd2;
        end else if (state_q == ST_IDLE && any_cyc_s) begin
            last_q <= grant_s;
        end else begin
            last_q <= last_q;
        end
    end
`else
    // Fixed priority: debug over CPU data over CPU instruction.
    always_comb begin
        grant_s = 2'd2;
        if (m0_cyc_i) begin
            grant_s = 2'd0;
        end else if (m1_cyc_i) begin
            grant_s = 2'd1;
        end else begin
            grant_s = 2'd2;
        end
    end
`endif

    // Select the owner's bus signals; an illegal owner code falls back to m0.
    always_comb begin
        o_adr_s = m0_adr_i;
        o_dat_s = m0_dat_i;
        o_sel_s = m0_sel_i;
        o_we_s  = m0_we_i;
        o_cyc_s = m0_cyc_i;
        o_stb_s = m0_stb_i;
        o_cti_s = m0_cti_i;
        o_bte_s = m0_bte_i;
        case (own_q)
            2'd1: begin
                o_adr_s = m1_adr_i;
                o_dat_s = m1_dat_i;
                o_sel_s = m1_sel_i;
                o_we_s  = m1_we_i;
                o_cyc_s = m1_cyc_i;
                o_stb_s = m1_stb_i;
                o_cti_s = m1_cti_i;
                o_bte_s = m1_bte_i;
            end
            2'd2: begin
                o_adr_s = m2_adr_i;
                o_dat_s = m2_dat_i;
                o_sel_s = m2_sel_i;
                o_we_s  = m2_we_i;
                o_cyc_s = m2_cyc_i;
                o_stb_s = m2_stb_i;
                o_cti_s = m2_cti_i;
                o_bte_s = m2_bte_i;
            end
            default: begin
                o_adr_s = m0_adr_i;
                o_dat_s = m0_dat_i;
                o_sel_s = m0_sel_i;
                o_we_s  = m0_we_i;
                o_cyc_s = m0_cyc_i;
                o_stb_s = m0_stb_i;
                o_cti_s = m0_cti_i;
                o_bte_s = m0_bte_i;
            end
        endcase
    end

    // Reset gates the bus directly so strobes drop without waiting for an edge.
    assign busy_s    = (state_q == ST_BUSY) && !wb_rst_i;
    assign resp_s    = s_ack_i | s_err_i | s_rty_i;
    assign timeout_s = busy_s && o_stb_s && !resp_s && (cnt_q == CW'(TIMEOUT - 1));

    // Watchdog counts stalled strobed cycles of the current transfer.
    always_comb begin
        cnt_d = '0;
        if (!busy_s || !o_stb_s || resp_s || timeout_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Ownership FSM: grant on any request, release only when the owner drops cyc.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            own_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (any_cyc_s) begin
                        state_q <= ST_BUSY;
                        own_q   <= grant_s;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (!o_cyc_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_BUSY;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_adr_o = o_adr_s;
    assign s_dat_o = o_dat_s;
    assign s_sel_o = o_sel_s;
    assign s_we_o  = o_we_s;
    assign s_cti_o = o_cti_s;
    assign s_bte_o = o_bte_s;
    assign s_cyc_o = busy_s & o_cyc_s;
    assign s_stb_o = busy_s & o_stb_s & ~timeout_s;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m2_dat_o = s_dat_i;

    // Responses reach the owner only; the watchdog error is merged into err.
    assign m0_ack_o = busy_s && (own_q == 2'd0) && s_ack_i;
    assign m1_ack_o = busy_s && (own_q == 2'd1) && s_ack_i;
    assign m2_ack_o = busy_s && (own_q == 2'd2) && s_ack_i;
    assign m0_err_o = busy_s && (own_q == 2'd0) && (s_err_i || timeout_s);
    assign m1_err_o = busy_s && (own_q == 2'd1) && (s_err_i || timeout_s);
    assign m2_err_o = busy_s && (own_q == 2'd2) && (s_err_i || timeout_s);
    assign m0_rty_o = busy_s && (own_q == 2'd0) && s_rty_i;
    assign m1_rty_o = busy_s && (own_q == 2'd1) && s_rty_i;
    assign m2_rty_o = busy_s && (own_q == 2'd2) && s_rty_i;

endmodule
